// File: rtl/wordline_req_encoder_8x3.sv
// Row-request arbiter/encoder feeding the 3x8 wordline decoder stage.
// Optional saturating collision counter: define ENC_COLLISION_CNT_EN.
module wordline_req_encoder_8x3 #(
  parameter int N_REQ       = 8,
  parameter int ADDR_W      = 3,
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [N_REQ-1:0]  req,
  input  logic              addr_ready,
`ifdef ENC_COLLISION_CNT_EN
  input  logic              coll_clr,
  output logic [7:0]        coll_cnt,
`endif
  output logic [ADDR_W-1:0] addr,
  output logic              addr_valid,
  output logic [N_REQ-1:0]  grant,
  output logic              collision
);

  typedef enum logic {
    IDLE,
    VALID
  } state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic               coll_q, coll_d;
  logic [ADDR_W-1:0]  ptr_q, ptr_d;

  logic [ADDR_W-1:0]  win;
  logic [ADDR_W-1:0]  idx;
  logic [ADDR_W-1:0]  base;
  logic               found;
  logic               capture;
  logic               accept;

  assign capture = (state_q == IDLE) && en && (|req);
  assign accept  = (state_q == VALID) && addr_ready;

  // Search upward from base with natural 3-bit wrap.
  always_comb begin
    win   = '0;
    idx   = '0;
    found = 1'b0;
    base  = ROUND_ROBIN ? ptr_q : '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = base + ADDR_W'(i);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    grant_d = grant_q;
    coll_d  = coll_q;
    ptr_d   = ptr_q;
    unique case (1'b1)
      capture: begin
        state_d = VALID;
        addr_d  = win;
        grant_d = N_REQ'(1) << win;
        coll_d  = |(req & (req - N_REQ'(1)));
      end
      accept: begin
        state_d = IDLE;
        grant_d = '0;
        coll_d  = 1'b0;
        if (ROUND_ROBIN)
          ptr_d = addr_q + ADDR_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      grant_q <= '0;
      coll_q  <= 1'b0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      grant_q <= grant_d;
      coll_q  <= coll_d;
      ptr_q   <= ptr_d;
    end
  end

  assign addr       = addr_q;
  assign addr_valid = (state_q == VALID);
  assign grant      = grant_q;
  assign collision  = coll_q;

`ifdef ENC_COLLISION_CNT_EN
  logic [7:0] cnt_q;

  // Clear wins over increment; count sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else if (coll_clr)
      cnt_q <= '0;
    else if (capture && coll_d && (cnt_q != 8'hFF))
      cnt_q <= cnt_q + 8'd1;
  end

  assign coll_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_wordline_req_encoder_8x3.sv
// Randomized bench for wordline_req_encoder_8x3 (rotating and fixed
// priority instances in lockstep) against a transaction-level model.
module tb_wordline_req_encoder_8x3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [7:0] req;
  logic       addr_ready;
  logic       coll_clr;

  logic [2:0] addr_rr, addr_fp;
  logic       vld_rr, vld_fp;
  logic [7:0] gnt_rr, gnt_fp;
  logic       col_rr, col_fp;
  logic [7:0] cnt_rr, cnt_fp;

  int n_chk  = 0;
  int n_fail = 0;

  bit m_valid;
  int m_addr_rr, m_addr_fp;
  bit m_coll;
  int m_ptr;
  int m_cnt;

  always #5 clk = ~clk;

  wordline_req_encoder_8x3 #(.ROUND_ROBIN(1'b1)) u_rr (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .req        (req),
    .addr_ready (addr_ready),
`ifdef ENC_COLLISION_CNT_EN
    .coll_clr   (coll_clr),
    .coll_cnt   (cnt_rr),
`endif
    .addr       (addr_rr),
    .addr_valid (vld_rr),
    .grant      (gnt_rr),
    .collision  (col_rr)
  );

  wordline_req_encoder_8x3 #(.ROUND_ROBIN(1'b0)) u_fp (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .req        (req),
    .addr_ready (addr_ready),
`ifdef ENC_COLLISION_CNT_EN
    .coll_clr   (coll_clr),
    .coll_cnt   (cnt_fp),
`endif
    .addr       (addr_fp),
    .addr_valid (vld_fp),
    .grant      (gnt_fp),
    .collision  (col_fp)
  );

`ifndef ENC_COLLISION_CNT_EN
  assign cnt_rr = '0;
  assign cnt_fp = '0;
`endif

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_win(logic [7:0] r, int p);
    for (int i = 0; i < 8; i++)
      if (r[(p + i) % 8]) return (p + i) % 8;
    return 0;
  endfunction

  function automatic int fp_win(logic [7:0] r);
    for (int i = 0; i < 8; i++)
      if (r[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    m_valid   = 0;
    m_addr_rr = 0;
    m_addr_fp = 0;
    m_coll    = 0;
    m_ptr     = 0;
    m_cnt     = 0;
  endtask

  task automatic model_edge();
    bit cap;
    cap = 0;
    if (!m_valid) begin
      if (en && req != 0) begin
        cap       = 1;
        m_valid   = 1;
        m_addr_rr = rr_win(req, m_ptr);
        m_addr_fp = fp_win(req);
        m_coll    = ($countones(req) > 1);
      end
    end else if (addr_ready) begin
      m_valid = 0;
      m_coll  = 0;
      m_ptr   = (m_addr_rr + 1) % 8;
    end
    if (coll_clr) m_cnt = 0;
    else if (cap && m_coll && m_cnt < 255) m_cnt++;
  endtask

  task automatic check_all(string tag);
    logic [7:0] g_rr, g_fp;
    g_rr = m_valid ? (8'd1 << m_addr_rr) : 8'd0;
    g_fp = m_valid ? (8'd1 << m_addr_fp) : 8'd0;
    chk({tag, "_vld_rr"}, 32'(vld_rr), 32'(m_valid));
    chk({tag, "_vld_fp"}, 32'(vld_fp), 32'(m_valid));
    chk({tag, "_addr_rr"}, 32'(addr_rr), 32'(m_addr_rr));
    chk({tag, "_addr_fp"}, 32'(addr_fp), 32'(m_addr_fp));
    chk({tag, "_gnt_rr"}, 32'(gnt_rr), 32'(g_rr));
    chk({tag, "_gnt_fp"}, 32'(gnt_fp), 32'(g_fp));
    chk({tag, "_col_rr"}, 32'(col_rr), 32'(m_coll));
    chk({tag, "_col_fp"}, 32'(col_fp), 32'(m_coll));
`ifdef ENC_COLLISION_CNT_EN
    chk({tag, "_cnt_rr"}, 32'(cnt_rr), 32'(m_cnt));
    chk({tag, "_cnt_fp"}, 32'(cnt_fp), 32'(m_cnt));
`endif
  endtask

  task automatic step(string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  // Reset asserted between edges, released before the next one.
  task automatic mid_reset(string tag);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic drain();
    req        = 8'h00;
    addr_ready = 1'b1;
    step("drain");
    step("drain");
  endtask

  initial begin
    rst_n      = 1'b0;
    en         = 1'b0;
    req        = 8'h00;
    addr_ready = 1'b0;
    coll_clr   = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    en  = 1'b1;
    req = 8'h20;
    step("cap5");
    chk("cap5_addr", 32'(addr_rr), 32'd5);
    mid_reset("midrst");
    req = 8'h01;
    step("post_rst");
    chk("post_rst_addr", 32'(addr_rr), 32'd0);
    drain();

    req        = 8'h10;
    addr_ready = 1'b1;
    step("single");
    chk("single_addr", 32'(addr_rr), 32'd4);
    chk("single_gnt", 32'(gnt_rr), 32'h10);
    for (int i = 0; i < 5; i++) step("single_rep");
    drain();

    req = 8'hFF;
    for (int i = 0; i < 18; i++) step("rr_ff");
    drain();

    req        = 8'h24;
    addr_ready = 1'b0;
    step("bp_cap");
    req = 8'h80;
    for (int i = 0; i < 5; i++) step("bp_hold");
    req        = 8'h24;
    addr_ready = 1'b1;
    for (int i = 0; i < 4; i++) step("bp_done");
    drain();

    req = 8'hC6;
    for (int i = 0; i < 6; i++) step("fp_c6");
    chk("fp_c6_addr", 32'(addr_fp), 32'd1);
    drain();

    en         = 1'b0;
    req        = 8'h08;
    addr_ready = 1'b0;
    step("en_off");
    step("en_off");
    en = 1'b1;
    step("en_on");
    chk("en_on_addr", 32'(addr_rr), 32'd3);
    en = 1'b0;
    for (int i = 0; i < 3; i++) step("en_drop");
    addr_ready = 1'b1;
    step("en_acc");
    en = 1'b1;
    drain();

`ifdef ENC_COLLISION_CNT_EN
    req        = 8'h03;
    addr_ready = 1'b1;
    for (int i = 0; i < 600; i++) step("cnt_sat");
    chk("cnt_sat_val", 32'(cnt_rr), 32'd255);
    coll_clr = 1'b1;
    step("cnt_clr");
    coll_clr = 1'b0;
    chk("cnt_clr_val", 32'(cnt_rr), 32'd0);
    drain();
`endif

    for (int i = 0; i < 3000; i++) begin
      en = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 7))
        0: req = 8'h00;
        1: req = 8'hFF;
        2: req = 8'd1 << $urandom_range(0, 7);
        default: req = 8'($urandom);
      endcase
      addr_ready = ($urandom_range(0, 2) != 0);
      coll_clr   = ($urandom_range(0, 63) == 0);
      step("rand");
      if ($urandom_range(0, 199) == 0) mid_reset("rand_rst");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
